// File: rtl/exe_unit_w2.sv
// ============================================================================
// Module   : exe_unit_w2
// Brief    : Parametrised execution unit, valid/ready issue. Single-cycle
//            add/sub/logic/shift; optional iterative shift-add multiply
//            enabled by macro EXE_UNIT_W2_MUL_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module exe_unit_w2 #(
    parameter int M = 8,
    parameter int N = 3
) (
    input  logic         i_clk,
    input  logic         i_rsn,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_oper,
    input  logic [M-1:0] i_argA,
    input  logic [M-1:0] i_argB,
    output logic         o_valid,
    output logic [M-1:0] o_result,
    output logic [3:0]   o_status
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [M:0] M_VAL  = (M+1)'(M);

    logic         hi_zero;
    logic         accept;
    logic         is_mul;
    logic [M-1:0] sc_res;
    logic         sc_carry;
    logic         sc_err;
    logic [M:0]   add_ext;
    logic [M:0]   sub_ext;
    logic [2*M-1:0] shl_ext;

    // Opcodes wider than 3 bits are only legal when the upper bits are zero.
    generate
        if (N > 3) begin : g_hi_bits
            assign hi_zero = (i_oper[N-1:3] == '0);
        end else begin : g_no_hi_bits
            assign hi_zero = 1'b1;
        end
    endgenerate

    assign add_ext = {1'b0, i_argA} + {1'b0, i_argB};
    assign sub_ext = {1'b0, i_argA} - {1'b0, i_argB};
    assign shl_ext = {{M{1'b0}}, i_argA} << i_argB;

    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_err   = 1'b0;
        if (!hi_zero) begin
            sc_err = 1'b1;
        end else begin
            case (i_oper[2:0])
                OP_ADD: begin
                    sc_res   = add_ext[M-1:0];
                    sc_carry = add_ext[M];
                end
                OP_SUB: begin
                    sc_res   = sub_ext[M-1:0];
                    sc_carry = (i_argA < i_argB);
                end
                OP_AND: sc_res = i_argA & i_argB;
                OP_OR:  sc_res = i_argA | i_argB;
                OP_XOR: sc_res = i_argA ^ i_argB;
                OP_SHL: begin
                    if ({1'b0, i_argB} >= M_VAL) begin
                        sc_res   = '0;
                        sc_carry = |i_argA;
                    end else begin
                        sc_res   = shl_ext[M-1:0];
                        sc_carry = |shl_ext[2*M-1:M];
                    end
                end
                default: sc_err = 1'b1;
            endcase
        end
    end

`ifdef EXE_UNIT_W2_MUL_EN
    localparam int CW = $clog2(M + 1);
    localparam logic [0:0]    IDLE     = 1'b0;
    localparam logic [0:0]    MUL_BUSY = 1'b1;
    localparam logic [CW-1:0] LAST_IT  = CW'(M - 1);

    logic [0:0]     state;
    logic [CW-1:0]  count;
    logic [2*M-1:0] mcand;
    logic [M-1:0]   mplr;
    logic [2*M-1:0] acc;
    logic [2*M-1:0] acc_next;

    assign o_ready  = (state == IDLE);
    assign is_mul   = hi_zero && (i_oper[2:0] == OP_MUL);
    assign acc_next = acc + (mplr[0] ? mcand : '0);
`else
    assign o_ready  = 1'b1;
    assign is_mul   = 1'b0;
`endif

    assign accept = i_valid && o_ready;

    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            o_valid  <= 1'b0;
            o_result <= '0;
            o_status <= '0;
`ifdef EXE_UNIT_W2_MUL_EN
            state    <= IDLE;
            count    <= '0;
            mcand    <= '0;
            mplr     <= '0;
            acc      <= '0;
`endif
        end else begin
            o_valid <= 1'b0;
`ifdef EXE_UNIT_W2_MUL_EN
            if (state == MUL_BUSY) begin
                acc   <= acc_next;
                mcand <= mcand << 1;
                mplr  <= mplr >> 1;
                if (count == LAST_IT) begin
                    state    <= IDLE;
                    count    <= '0;
                    o_valid  <= 1'b1;
                    o_result <= acc_next[M-1:0];
                    o_status <= {1'b0, |acc_next[2*M-1:M], acc_next[M-1],
                                 (acc_next[M-1:0] == '0)};
                end else begin
                    count <= count + 1'b1;
                end
            end else if (accept && is_mul) begin
                state <= MUL_BUSY;
                count <= '0;
                mcand <= {{M{1'b0}}, i_argA};
                mplr  <= i_argB;
                acc   <= '0;
            end else
`endif
            if (accept && !is_mul) begin
                o_valid  <= 1'b1;
                o_result <= sc_res;
                o_status <= {sc_err, sc_carry, sc_res[M-1], (sc_res == '0)};
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_exe_unit_w2.sv
// ============================================================================
// Module   : tb_exe_unit_w2
// Brief    : Directed self-checking bench for exe_unit_w2 (M=8, N=3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exe_unit_w2;

    localparam int M = 8;
    localparam int N = 3;

    logic         clk;
    logic         clk_en;
    logic         rst_n;
    logic         valid_in;
    logic         ready;
    logic [N-1:0] oper;
    logic [M-1:0] arg_a;
    logic [M-1:0] arg_b;
    logic         valid_out;
    logic [M-1:0] result;
    logic [3:0]   status;

    int n_checks;
    int n_fail;

    exe_unit_w2 #(.M(M), .N(N)) dut (
        .i_clk    (clk),
        .i_rsn    (rst_n),
        .i_valid  (valid_in),
        .o_ready  (ready),
        .i_oper   (oper),
        .i_argA   (arg_a),
        .i_argB   (arg_b),
        .o_valid  (valid_out),
        .o_result (result),
        .o_status (status)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request, let one rising edge pass, sample #1 later.
    task automatic issue(input logic [N-1:0] op, input logic [M-1:0] a, input logic [M-1:0] b);
        valid_in = 1'b1;
        oper     = op;
        arg_a    = a;
        arg_b    = b;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    initial begin
        int bad;
        int pulses;
        int cyc;
        n_checks = 0;
        n_fail   = 0;
        clk      = 1'b0;
        clk_en   = 1'b0;
        rst_n    = 1'b1;
        valid_in = 1'b0;
        oper     = '0;
        arg_a    = '0;
        arg_b    = '0;

        // Reset with clock stopped: outputs must settle asynchronously.
        #5 rst_n = 1'b0;
        #1;
        check("rst_result", 32'(result), 32'h0);
        check("rst_status", 32'(status), 32'h0);
        check("rst_valid", 32'(valid_out), 32'h0);
        check("rst_ready", 32'(ready), 32'h1);
        clk_en = 1'b1;
        #14 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_valid", 32'(valid_out), 32'h0);
        check("idle_result", 32'(result), 32'h0);

        issue(3'b000, 8'd200, 8'd100);
        check("add_valid", 32'(valid_out), 32'h1);
        check("add_result", 32'(result), 32'h2C);
        check("add_status", 32'(status), 32'b0100);
        issue(3'b001, 8'd5, 8'd7);
        check("sub_valid", 32'(valid_out), 32'h1);
        check("sub_result", 32'(result), 32'hFE);
        check("sub_status", 32'(status), 32'b0110);

        issue(3'b101, 8'h81, 8'd1);
        check("shl1_result", 32'(result), 32'h02);
        check("shl1_status", 32'(status), 32'b0100);
        issue(3'b101, 8'h81, 8'd9);
        check("shl9_result", 32'(result), 32'h00);
        check("shl9_status", 32'(status), 32'b0101);

        issue(3'b011, 8'hA0, 8'h05);
        check("or_result", 32'(result), 32'hA5);
        check("or_status", 32'(status), 32'b0010);
        @(posedge clk);
        #1;
        check("valid_drop", 32'(valid_out), 32'h0);
        check("hold_result", 32'(result), 32'hA5);

        issue(3'b111, 8'h12, 8'h34);
        check("ill7_result", 32'(result), 32'h0);
        check("ill7_status", 32'(status), 32'b1001);
        check("ill7_valid", 32'(valid_out), 32'h1);

`ifdef EXE_UNIT_W2_MUL_EN
        // 15*17: o_valid exactly M edges after accept, ready low before.
        issue(3'b110, 8'd15, 8'd17);
        bad = 0;
        for (int k = 1; k < M; k++) begin
            if (valid_out !== 1'b0 || ready !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        if (valid_out !== 1'b0 || ready !== 1'b0) bad++;
        check("mul_busy_window", 32'(bad), 32'h0);
        @(posedge clk);
        #1;
        check("mul15_valid", 32'(valid_out), 32'h1);
        check("mul15_result", 32'(result), 32'hFF);
        check("mul15_status", 32'(status), 32'b0010);
        check("mul15_ready", 32'(ready), 32'h1);

        issue(3'b110, 8'd16, 8'd16);
        repeat (M) @(posedge clk);
        #1;
        check("mul16_valid", 32'(valid_out), 32'h1);
        check("mul16_result", 32'(result), 32'h00);
        check("mul16_status", 32'(status), 32'b0101);

        // Add held on i_valid while busy is taken only after the mul result.
        issue(3'b110, 8'd3, 8'd4);
        valid_in = 1'b1;
        oper     = 3'b000;
        arg_a    = 8'd1;
        arg_b    = 8'd2;
        cyc = 0;
        while (valid_out !== 1'b1 && cyc < 4 * M) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("hold_mul_latency", 32'(cyc), 32'(M));
        check("hold_mul_result", 32'(result), 32'd12);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        check("hold_add_valid", 32'(valid_out), 32'h1);
        check("hold_add_result", 32'(result), 32'd3);

        // Reset in the middle of a multiply.
        issue(3'b110, 8'd15, 8'd17);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_result", 32'(result), 32'h0);
        check("midrst_status", 32'(status), 32'h0);
        check("midrst_ready", 32'(ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < M + 4; k++) begin
            @(posedge clk);
            #1;
            if (valid_out === 1'b1) pulses++;
        end
        check("midrst_no_pulse", 32'(pulses), 32'h0);
`else
        issue(3'b110, 8'd15, 8'd17);
        check("ill6_valid", 32'(valid_out), 32'h1);
        check("ill6_result", 32'(result), 32'h0);
        check("ill6_status", 32'(status), 32'b1001);
        bad = 0;
        for (int k = 0; k < M + 2; k++) begin
            valid_in = 1'b1;
            oper     = 3'b110;
            @(negedge clk);
            if (ready !== 1'b1) bad++;
            @(posedge clk);
            #1;
            if (ready !== 1'b1) bad++;
        end
        valid_in = 1'b0;
        check("ill6_ready_high", 32'(bad), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
